// File: rtl/fifo_sram_ctrl_pkg.sv
// Shared state encoding and default sizing for the SRAM-backed FIFO controller.
package fifo_sram_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_STROBE = 2'd2,
      ST_RECOV  = 2'd3
   } state_t;

   localparam int DEF_DATA_W    = 8;
   localparam int DEF_ADDR_W    = 11;
   localparam int DEF_DEPTH     = 8;
   localparam int DEF_WAIT_CYC  = 2;
   localparam int DEF_AEMPTY_TH = 2;

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// FIFO bookkeeping: wrapping pointers, word count, registered level flags and
// sticky error flags. Count and flags only move on inc_wr/inc_rd pulses.
module fifo_ptr_ctrl #(
   parameter int ADDR_W    = 11,
   parameter int DEPTH     = 8,
   parameter int AFULL_TH  = 6,
   parameter int AEMPTY_TH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inc_wr,
   input  logic              inc_rd,
   input  logic              set_ovf,
   input  logic              set_udf,
   output logic [ADDR_W-1:0] wr_ptr,
   output logic [ADDR_W-1:0] rd_ptr,
   output logic [ADDR_W:0]   count,
   output logic              nfull,
   output logic              nempty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic              overflow,
   output logic              underflow
);

   localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   AF_TH    = (ADDR_W+1)'(AFULL_TH);
   localparam logic [ADDR_W:0]   AE_TH    = (ADDR_W+1)'(AEMPTY_TH);

   logic [ADDR_W:0] cnt_nxt;

   always_comb begin
      cnt_nxt = count;
      if (inc_wr && !inc_rd)
         cnt_nxt = count + CNT_ONE;
      else if (inc_rd && !inc_wr)
         cnt_nxt = count - CNT_ONE;
   end

   // Flags are registered from the post-update count so they settle on the same edge as count.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         nfull        <= 1'b1;
         nempty       <= 1'b0;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         if (inc_wr)
            wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
         if (inc_rd)
            rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
         count        <= cnt_nxt;
         nfull        <= (cnt_nxt != CNT_FULL);
         nempty       <= (cnt_nxt != '0);
         almost_full  <= (cnt_nxt >= AF_TH);
         almost_empty <= (cnt_nxt <= AE_TH);
         if (set_ovf)
            overflow <= 1'b1;
         if (set_udf)
            underflow <= 1'b1;
      end
   end

endmodule

// File: rtl/fifo_sram_ctrl.sv
// FIFO controller storing words in an external asynchronous SRAM through a
// setup / strobe / recovery bus sequencer.
//
//   state     | meaning
//   ST_IDLE   | waiting for a request; busy low
//   ST_SETUP  | address (and write data) presented, strobes high
//   ST_STROBE | rd or wr low for WAIT_CYC clocks; read data sampled on last edge
//   ST_RECOV  | strobes high; out_valid on reads; pending write restarts SETUP
module fifo_sram_ctrl
   import fifo_sram_ctrl_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int WAIT_CYC  = DEF_WAIT_CYC,
   parameter int AFULL_TH  = DEPTH - 2,
   parameter int AEMPTY_TH = DEF_AEMPTY_TH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_req,
   input  logic              rd_req,
   input  logic [DATA_W-1:0] in_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              busy,
   output logic              nfull,
   output logic              nempty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              underflow,
   output logic [ADDR_W-1:0] address,
   inout  wire  [DATA_W-1:0] sram_data,
   output logic              rd,
   output logic              wr
);

   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC - 1);

   state_t            state, state_nxt;
   logic              op_wr, pend_wr, drive;
   logic [DATA_W-1:0] wdata, pend_data;
   logic [3:0]        wait_cnt;
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic              start_rd, start_wr, queue_wr, set_ovf, set_udf;
   logic              inc_wr, inc_rd;

   // Request arbitration: a non-empty read wins and parks the write; an empty
   // read alongside a write is dropped as an underflow.
   always_comb begin
      start_rd = 1'b0;
      start_wr = 1'b0;
      queue_wr = 1'b0;
      set_ovf  = 1'b0;
      set_udf  = 1'b0;
      if (state == ST_IDLE) begin
         if (rd_req && nempty) begin
            start_rd = 1'b1;
            queue_wr = wr_req;
         end else if (wr_req) begin
            set_udf = rd_req;
            if (nfull)
               start_wr = 1'b1;
            else
               set_ovf = 1'b1;
         end else if (rd_req) begin
            set_udf = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      rd        = 1'b1;
      wr        = 1'b1;
      out_valid = 1'b0;
      drive     = 1'b0;
      busy      = (state != ST_IDLE);
      case (state)
         ST_IDLE: begin
            if (start_rd || start_wr)
               state_nxt = ST_SETUP;
         end
         ST_SETUP: begin
            drive     = op_wr;
            state_nxt = ST_STROBE;
         end
         ST_STROBE: begin
            drive = op_wr;
            rd    = op_wr;
            wr    = !op_wr;
            if (wait_cnt == 4'd0)
               state_nxt = ST_RECOV;
         end
         ST_RECOV: begin
            drive     = op_wr;
            out_valid = !op_wr;
            state_nxt = pend_wr ? ST_SETUP : ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign inc_wr    = (state == ST_STROBE) && (wait_cnt == 4'd0) && op_wr;
   assign inc_rd    = (state == ST_STROBE) && (wait_cnt == 4'd0) && !op_wr;
   assign sram_data = drive ? wdata : {DATA_W{1'bz}};

   always_ff @(posedge clk) begin
      if (rst) begin
         op_wr     <= 1'b0;
         pend_wr   <= 1'b0;
         pend_data <= '0;
         wdata     <= '0;
         wait_cnt  <= '0;
         address   <= '0;
         out_data  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_rd) begin
                  op_wr     <= 1'b0;
                  address   <= rd_ptr;
                  pend_wr   <= queue_wr;
                  pend_data <= in_data;
               end else if (start_wr) begin
                  op_wr   <= 1'b1;
                  address <= wr_ptr;
                  wdata   <= in_data;
               end
            end
            ST_SETUP: wait_cnt <= WAIT_LD;
            ST_STROBE: begin
               if (wait_cnt != 4'd0)
                  wait_cnt <= wait_cnt - 4'd1;
               else if (!op_wr)
                  out_data <= sram_data;
            end
            ST_RECOV: begin
               if (pend_wr) begin
                  op_wr   <= 1'b1;
                  address <= wr_ptr;
                  wdata   <= pend_data;
                  pend_wr <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   fifo_ptr_ctrl #(
      .ADDR_W    (ADDR_W),
      .DEPTH     (DEPTH),
      .AFULL_TH  (AFULL_TH),
      .AEMPTY_TH (AEMPTY_TH)
   ) u_ptr (
      .clk          (clk),
      .rst          (rst),
      .inc_wr       (inc_wr),
      .inc_rd       (inc_rd),
      .set_ovf      (set_ovf),
      .set_udf      (set_udf),
      .wr_ptr       (wr_ptr),
      .rd_ptr       (rd_ptr),
      .count        (count),
      .nfull        (nfull),
      .nempty       (nempty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .overflow     (overflow),
      .underflow    (underflow)
   );

endmodule

// File: tb/tb_fifo_sram_ctrl.sv
// Directed bench for fifo_sram_ctrl against a behavioural asynchronous SRAM.
module tb_fifo_sram_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wr_req = 1'b0;
   logic        rd_req = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic [7:0]  out_data;
   logic        out_valid, busy, nfull, nempty, almost_full, almost_empty;
   logic [11:0] count;
   logic        overflow, underflow;
   logic [10:0] address;
   wire  [7:0]  sram_data;
   logic        rd, wr;

   logic [7:0]  mem [0:2047];
   int          checks = 0;
   int          errors = 0;

   logic [7:0]  wdat [8] = '{8'hA5, 8'h3C, 8'h5A, 8'hC3, 8'h0F, 8'hF0, 8'h96, 8'h69};

   always #5 clk = ~clk;

   fifo_sram_ctrl #(
      .DATA_W   (8),
      .ADDR_W   (11),
      .DEPTH    (8),
      .WAIT_CYC (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .wr_req       (wr_req),
      .rd_req       (rd_req),
      .in_data      (in_data),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .busy         (busy),
      .nfull        (nfull),
      .nempty       (nempty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow),
      .address      (address),
      .sram_data    (sram_data),
      .rd           (rd),
      .wr           (wr)
   );

   // Asynchronous SRAM: drives on output-enable, writes while write-enable is low.
   assign sram_data = (!rd) ? mem[address] : 8'bz;
   always @(posedge clk) if (!wr) mem[address] <= sram_data;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // One request pulse, then observe the whole busy window on falling edges.
   task automatic op(input bit w, input bit r, input logic [7:0] d,
                     output int bn, output int wn, output int rn, output int vn,
                     output logic [7:0] ro, output logic [10:0] ad);
      int guard;
      bn = 0; wn = 0; rn = 0; vn = 0; ro = 8'h00; ad = '0; guard = 0;
      @(negedge clk);
      wr_req = w; rd_req = r; in_data = d;
      @(negedge clk);
      wr_req = 1'b0; rd_req = 1'b0;
      ad = address;
      while (busy && guard < 50) begin
         bn++;
         if (!wr) wn++;
         if (!rd) rn++;
         if (out_valid) begin vn++; ro = out_data; end
         guard++;
         @(negedge clk);
      end
      if (guard >= 50) check("busy_timeout", 32'(guard), 32'd0);
   endtask

   initial begin
      int bn, wn, rn, vn;
      logic [7:0] ro, d;
      logic [10:0] ad;

      for (int i = 0; i < 2048; i++) mem[i] = 8'h00;

      do_reset();
      check("rst_busy", busy, 1'b0);
      check("rst_nfull", nfull, 1'b1);
      check("rst_nempty", nempty, 1'b0);
      check("rst_afull", almost_full, 1'b0);
      check("rst_aempty", almost_empty, 1'b1);
      check("rst_ovf", overflow, 1'b0);
      check("rst_udf", underflow, 1'b0);
      check("rst_rdwr", {rd, wr}, 2'b11);
      check("rst_addr", address, 11'd0);
      check("rst_count", count, 12'd0);
      check("rst_out", {out_valid, out_data}, 9'h000);

      // read while empty
      op(1'b0, 1'b1, 8'h00, bn, wn, rn, vn, ro, ad);
      check("empty_rd_busy", bn, 0);
      check("empty_rd_strobe", rn, 0);
      check("empty_rd_udf", underflow, 1'b1);
      check("empty_rd_nempty", nempty, 1'b0);
      check("empty_rd_out", out_data, 8'h00);

      // fill
      for (int i = 0; i < 8; i++) begin
         op(1'b1, 1'b0, wdat[i], bn, wn, rn, vn, ro, ad);
         check("fill_wr_low", wn, 2);
         check("fill_busy", bn, 4);
         check("fill_count", count, 12'(i + 1));
         check("fill_afull", almost_full, (i + 1) >= 6);
         check("fill_nfull", nfull, (i + 1) != 8);
      end
      op(1'b1, 1'b0, 8'h11, bn, wn, rn, vn, ro, ad);
      check("full_wr_busy", bn, 0);
      check("full_wr_strobe", wn, 0);
      check("full_wr_ovf", overflow, 1'b1);
      check("full_wr_count", count, 12'd8);

      // drain
      for (int i = 0; i < 8; i++) begin
         op(1'b0, 1'b1, 8'h00, bn, wn, rn, vn, ro, ad);
         check("drain_data", ro, wdat[i]);
         check("drain_valid", vn, 1);
         check("drain_rd_low", rn, 2);
         check("drain_aempty", almost_empty, (7 - i) <= 2);
      end
      check("drain_nempty", nempty, 1'b0);
      check("drain_count", count, 12'd0);

      // interleaved pairs across two pointer wraps
      for (int i = 0; i < 16; i++) begin
         d = 8'(i * 13 + 1);
         op(1'b1, 1'b0, d, bn, wn, rn, vn, ro, ad);
         check("pair_wr_addr", ad, 11'(i % 8));
         op(1'b0, 1'b1, 8'h00, bn, wn, rn, vn, ro, ad);
         check("pair_rd_addr", ad, 11'(i % 8));
         check("pair_rd_data", ro, d);
      end
      check("pair_count", count, 12'd0);

      // simultaneous read+write with three words stored
      op(1'b1, 1'b0, 8'h11, bn, wn, rn, vn, ro, ad);
      op(1'b1, 1'b0, 8'h22, bn, wn, rn, vn, ro, ad);
      op(1'b1, 1'b0, 8'h33, bn, wn, rn, vn, ro, ad);
      op(1'b1, 1'b1, 8'h7E, bn, wn, rn, vn, ro, ad);
      check("both_busy", bn, 8);
      check("both_rd_low", rn, 2);
      check("both_wr_low", wn, 2);
      check("both_valid", vn, 1);
      check("both_data", ro, 8'h11);
      check("both_count", count, 12'd3);
      op(1'b0, 1'b1, 8'h00, bn, wn, rn, vn, ro, ad);
      check("both_rd1", ro, 8'h22);
      op(1'b0, 1'b1, 8'h00, bn, wn, rn, vn, ro, ad);
      check("both_rd2", ro, 8'h33);
      op(1'b0, 1'b1, 8'h00, bn, wn, rn, vn, ro, ad);
      check("both_rd3", ro, 8'h7E);

      // simultaneous read+write while empty
      do_reset();
      op(1'b1, 1'b1, 8'h44, bn, wn, rn, vn, ro, ad);
      check("both_empty_busy", bn, 4);
      check("both_empty_rd", rn, 0);
      check("both_empty_wr", wn, 2);
      check("both_empty_udf", underflow, 1'b1);
      check("both_empty_count", count, 12'd1);

      // reset during a write strobe
      do_reset();
      @(negedge clk);
      wr_req = 1'b1; in_data = 8'h99;
      @(negedge clk);
      wr_req = 1'b0;
      @(negedge clk);
      check("abort_in_strobe", wr, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_wr", wr, 1'b1);
      check("abort_busy", busy, 1'b0);
      check("abort_count", count, 12'd0);
      check("abort_flags", {nfull, nempty, almost_full, almost_empty, overflow, underflow}, 6'b100100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_sram_ctrl.md
FIFO_SRAM_CTRL -- requirements
Module: fifo_sram_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set FIFO word and SRAM data-bus width.
REQ-002 Parameter ADDR_W, default 11, SHALL set SRAM address width.
REQ-003 Parameter DEPTH, default 8, SHALL set FIFO capacity in words; legal range 2..2**ADDR_W.
REQ-004 Parameter WAIT_CYC, default 2, SHALL set SRAM strobe-low duration in clocks; legal range 1..15.
REQ-005 Parameters AFULL_TH (default DEPTH-2) and AEMPTY_TH (default 2) SHALL set the almost-flag thresholds.
REQ-006 Ports:
 clk  in  1  single clock, rising edge.
 rst  in  1  synchronous reset, active-high.
 wr_req  in  1  write request, active-high, one cycle, sampled only when busy=0.
 rd_req  in  1  read request, active-high, one cycle, sampled only when busy=0.
 in_data  in  DATA_W  write word, captured on the cycle wr_req is accepted.
 out_data  out  DATA_W  last word read.
 out_valid  out  1  one-cycle pulse; out_data is new.
 busy  out  1  SRAM cycle in progress or a write is pending.
 nfull  out  1  low when count==DEPTH.
 nempty  out  1  low when count==0.
 almost_full  out  1  count>=AFULL_TH.
 almost_empty  out  1  count<=AEMPTY_TH.
 count  out  ADDR_W+1  words stored.
 overflow  out  1  sticky; write attempted while full.
 underflow  out  1  sticky; read attempted while empty.
 address  out  ADDR_W  SRAM address.
 sram_data  inout  DATA_W  SRAM data bus; driven only while writing, high-Z otherwise.
 rd  out  1  SRAM output enable, active-low.
 wr  out  1  SRAM write enable, active-low.

Function
REQ-007 States: IDLE, SETUP, STROBE, RECOV.
REQ-008 In IDLE, an accepted request SHALL move the block to SETUP on the next edge; busy SHALL be high from that edge until IDLE is re-entered.
REQ-009 SETUP lasts 1 cycle: address valid; rd=wr=1; for writes, sram_data is driven.
REQ-010 STROBE lasts WAIT_CYC cycles with rd=0 (read) or wr=0 (write); address and write data are held stable.
REQ-011 On a read, sram_data SHALL be sampled at the last STROBE edge and loaded into out_data.
REQ-012 RECOV lasts 1 cycle: rd=wr=1; bus still driven on writes; out_valid=1 on reads; count, pointers and flags update on entry.
REQ-013 After RECOV the block SHALL return to IDLE; operation latency is WAIT_CYC+2 cycles from acceptance to IDLE.
REQ-014 Write and read pointers SHALL wrap from DEPTH-1 to 0, independent of 2**ADDR_W.
REQ-015 If wr_req and rd_req are both accepted in the same cycle and the FIFO is non-empty, the block SHALL perform the read first, latch in_data as a pending write, and start the write directly from RECOV into SETUP; busy SHALL stay high throughout.
REQ-016 If both are accepted while empty, the write SHALL execute, the read SHALL be dropped, and underflow SHALL set.
REQ-017 wr_req while full SHALL start no SRAM cycle and SHALL set overflow; rd_req while empty SHALL start no SRAM cycle, SHALL set underflow, and SHALL leave out_data unchanged.
REQ-018 Requests arriving while busy=1 SHALL be ignored without flagging.
REQ-019 Flags SHALL be registered, derived from the updated count, and never change during SETUP/STROBE.

Reset
REQ-020 rst=1 at a clock edge SHALL force: state IDLE, pointers 0, count 0, pending write cleared, out_data 0, out_valid 0, busy 0, nfull 1, nempty 0, almost_full 0, almost_empty 1, overflow 0, underflow 0, rd=1, wr=1, sram_data high-Z, address 0.
REQ-021 Reset in mid-operation SHALL abort the SRAM cycle on that same edge with no count change; stored data is discarded.

Structure
REQ-022 A shared package SHALL hold the state enumeration and the default parameter constants.
REQ-023 Pointer/count/flag logic SHALL be a sub-module fifo_ptr_ctrl; the SRAM sequencer and tristate stay in the top level.

Verification (DEPTH=8, DATA_W=8, WAIT_CYC=2, external SRAM model)
REQ-024 Reset, then a single read -> no rd strobe, underflow=1, nempty=0, out_data=00.
REQ-025 Write A5,3C,...(8 words) -> nfull=0 after 8th; 9th write sets overflow, no wr strobe; each write: wr low exactly 2 cycles, busy high 4 cycles.
REQ-026 Read 8 -> data in write order, out_valid once per read, almost_empty asserts at count 2, nempty=0 at end.
REQ-027 Write/read 16 interleaved pairs -> pointers wrap twice, address sequence 0..7,0..7, every compare passes.
REQ-028 count=3, wr_req+rd_req same cycle with in_data=7E -> read completes first, then write; busy high 8 cycles; count returns to 3.
REQ-029 rst asserted during STROBE of a write -> wr=1 next edge, count=0, flags at reset values.
